jtkcpu_pshpul: RTL and testbench

- Push/pull sequencer for PSHS/PSHU/PULS/PULU and interrupt state stacking.
- Walks a register mask and drives the memory controller's stack path (`psh_addr`/`psh_en`, `mem16`, `wrq`) one register at a time.
- Selects the register-file source/destination and tracks the working stack pointer.
- Sits between the control unit/register file and the memory controller.

---
 rtl/jtkcpu_pshpul_if.sv | 19 +
 rtl/jtkcpu_pshpul.sv | 183 ++++++++++++++++++
 tb/tb_jtkcpu_pshpul.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/jtkcpu_pshpul_if.sv
// Stack-path bus between the push/pull sequencer (master) and the memory controller (slave).
interface jtkcpu_pshpul_if;
  logic [15:0] psh_addr;
  logic        psh_en;
  logic        mem16;
  logic        wrq;
  logic        mem_busy;
  logic [15:0] mem_data;

  modport master (
    output psh_addr, psh_en, mem16, wrq,
    input  mem_busy, mem_data
  );

  modport slave (
    input  psh_addr, psh_en, mem16, wrq,
    output mem_busy, mem_data
  );
endinterface

// File: rtl/jtkcpu_pshpul.sv
// Push/pull sequencer for PSHS/PSHU/PULS/PULU and interrupt stacking.
// Define JTKCPU_FIRQ_EN to make int_stk with firq=1 push only PC and CC.
module jtkcpu_pshpul (
  input  logic                   rst,
  input  logic                   clk,
  input  logic                   cen,
  input  logic                   start,
  input  logic                   pull,
  input  logic                   use_u,
  input  logic                   int_stk,
  input  logic                   firq,
  input  logic [7:0]             postbyte,
  input  logic [15:0]            s_in,
  input  logic [15:0]            u_in,
  jtkcpu_pshpul_if.master        mem,
  output logic [2:0]             rsel,
  output logic                   ld,
  output logic [15:0]            sp_out,
  output logic                   sp_we,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StFin} state_e;

  state_e      state_q, state_d;
  logic [7:0]  mask_q, mask_d;
  logic        pull_q, pull_d;
  logic        waited_q, waited_d;
  logic [15:0] sp_q, sp_d;
  logic [15:0] psh_addr_q, psh_addr_d;
  logic        psh_en_q, psh_en_d;
  logic        mem16_q, mem16_d;
  logic        wrq_q, wrq_d;
  logic [2:0]  rsel_q, rsel_d;
  logic        ld_q, ld_d;
  logic [15:0] sp_out_q, sp_out_d;
  logic        sp_we_q, sp_we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [7:0]  frame;
  logic [2:0]  nxt;
  logic [15:0] sz;
  logic [7:0]  mask_clr;
  logic        unused_data;

  assign unused_data = ^mem.mem_data;

`ifdef JTKCPU_FIRQ_EN
  assign frame = firq ? 8'h81 : 8'hFF;
`else
  logic unused_firq;
  assign unused_firq = firq;
  assign frame = 8'hFF;
`endif

  // Push walks 7->0, pull walks 0->7; the last hit in each loop wins.
  always_comb begin
    nxt = 3'd0;
    if (pull_q) begin
      for (int i = 7; i >= 0; i--) if (mask_q[i]) nxt = 3'(i);
    end else begin
      for (int i = 0; i < 8; i++) if (mask_q[i]) nxt = 3'(i);
    end
  end

  assign sz       = {14'd0, nxt[2], ~nxt[2]};
  assign mask_clr = mask_q & ~(8'd1 << rsel_q);

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    pull_d     = pull_q;
    waited_d   = waited_q;
    sp_d       = sp_q;
    psh_addr_d = psh_addr_q;
    psh_en_d   = psh_en_q;
    mem16_d    = mem16_q;
    wrq_d      = 1'b0;
    rsel_d     = rsel_q;
    ld_d       = 1'b0;
    sp_out_d   = sp_out_q;
    sp_we_d    = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (int_stk) begin
          mask_d  = frame;
          pull_d  = 1'b0;
          sp_d    = s_in;
          busy_d  = 1'b1;
          state_d = StIssue;
        end else if (start) begin
          mask_d  = postbyte;
          pull_d  = pull;
          sp_d    = use_u ? u_in : s_in;
          busy_d  = 1'b1;
          state_d = (postbyte == 8'd0) ? StFin : StIssue;
        end
      end
      StIssue: begin
        rsel_d     = nxt;
        mem16_d    = nxt[2];
        psh_en_d   = 1'b1;
        wrq_d      = ~pull_q;
        waited_d   = 1'b0;
        psh_addr_d = pull_q ? sp_q : sp_q - sz;
        sp_d       = pull_q ? sp_q + sz : sp_q - sz;
        state_d    = StWait;
      end
      StWait: begin
        // First cen lets the controller take the request before mem_busy counts.
        if (!waited_q) begin
          waited_d = 1'b1;
        end else if (!mem.mem_busy) begin
          mask_d  = mask_clr;
          ld_d    = pull_q;
          state_d = (mask_clr == 8'd0) ? StFin : StIssue;
        end
      end
      StFin: begin
        sp_out_d = sp_q;
        sp_we_d  = 1'b1;
        done_d   = 1'b1;
        psh_en_d = 1'b0;
        mem16_d  = 1'b0;
        busy_d   = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      mask_q     <= 8'd0;
      pull_q     <= 1'b0;
      waited_q   <= 1'b0;
      sp_q       <= 16'd0;
      psh_addr_q <= 16'd0;
      psh_en_q   <= 1'b0;
      mem16_q    <= 1'b0;
      wrq_q      <= 1'b0;
      rsel_q     <= 3'd0;
      ld_q       <= 1'b0;
      sp_out_q   <= 16'd0;
      sp_we_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (cen) begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      pull_q     <= pull_d;
      waited_q   <= waited_d;
      sp_q       <= sp_d;
      psh_addr_q <= psh_addr_d;
      psh_en_q   <= psh_en_d;
      mem16_q    <= mem16_d;
      wrq_q      <= wrq_d;
      rsel_q     <= rsel_d;
      ld_q       <= ld_d;
      sp_out_q   <= sp_out_d;
      sp_we_q    <= sp_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem.psh_addr = psh_addr_q;
  assign mem.psh_en   = psh_en_q;
  assign mem.mem16    = mem16_q;
  assign mem.wrq      = wrq_q;
  assign rsel         = rsel_q;
  assign ld           = ld_q;
  assign sp_out       = sp_out_q;
  assign sp_we        = sp_we_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_jtkcpu_pshpul.sv
// Randomized bench for jtkcpu_pshpul against a transfer-list model of the stack sequence.
module tb_jtkcpu_pshpul;

  logic        rst, clk, cen, start, pull, use_u, int_stk, firq;
  logic [7:0]  postbyte;
  logic [15:0] s_in, u_in;
  logic [2:0]  rsel;
  logic        ld, sp_we, busy, done;
  logic [15:0] sp_out;

  jtkcpu_pshpul_if mem_if ();

  jtkcpu_pshpul u_dut (
    .rst      (rst),
    .clk      (clk),
    .cen      (cen),
    .start    (start),
    .pull     (pull),
    .use_u    (use_u),
    .int_stk  (int_stk),
    .firq     (firq),
    .postbyte (postbyte),
    .s_in     (s_in),
    .u_in     (u_in),
    .mem      (mem_if),
    .rsel     (rsel),
    .ld       (ld),
    .sp_out   (sp_out),
    .sp_we    (sp_we),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0]  exp_rsel[$];
  logic [15:0] exp_addr[$];
  logic        exp_m16[$];
  logic [15:0] exp_sp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] int_frame(input logic fq);
`ifdef JTKCPU_FIRQ_EN
    return fq ? 8'h81 : 8'hFF;
`else
    return (fq === 1'bx) ? 8'h00 : 8'hFF;
`endif
  endfunction

  // Expected transfer list: one entry per set mask bit in scan order.
  task automatic build_model(input logic [15:0] sp0, input logic [7:0] m, input logic pl);
    logic [15:0] sp;
    sp = sp0;
    exp_rsel.delete();
    exp_addr.delete();
    exp_m16.delete();
    for (int k = 0; k < 8; k++) begin
      int b;
      int sz;
      b  = pl ? k : 7 - k;
      sz = (b >= 4) ? 2 : 1;
      if (m[b]) begin
        if (pl) begin
          exp_addr.push_back(sp);
          sp = sp + 16'(sz);
        end else begin
          sp = sp - 16'(sz);
          exp_addr.push_back(sp);
        end
        exp_rsel.push_back(3'(b));
        exp_m16.push_back(b >= 4);
      end
    end
    exp_sp = sp;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_seq(input string name, input logic [15:0] s, input logic [15:0] u,
                         input logic [7:0] pb, input logic pl, input logic uu, input logic ik,
                         input logic fq, input bit rand_cen, input bit stall, input int exp_final);
    logic [7:0]  m;
    logic        epl;
    logic        prev_en, prev_ld;
    logic [2:0]  prev_rsel;
    logic [15:0] stall_addr;
    int          idx, ld_cnt, stall_cnt, cyc;
    bit          got_done;
    m   = ik ? int_frame(fq) : pb;
    epl = ik ? 1'b0 : pl;
    build_model(ik ? s : (uu ? u : s), m, epl);
    s_in = s; u_in = u; postbyte = pb; use_u = uu; firq = fq; int_stk = ik;
    pull  = ik ? 1'($urandom_range(0, 1)) : pl;
    start = ik ? 1'($urandom_range(0, 1)) : 1'b1;
    cen = 1'b1; mem_if.mem_busy = 1'b0;
    step();
    start = 1'b0; int_stk = 1'b0;
    s_in = 16'($urandom); u_in = 16'($urandom); postbyte = 8'($urandom);
    pull = 1'($urandom_range(0, 1)); use_u = 1'($urandom_range(0, 1));
    check_eq({name, ".busy_up"}, {31'd0, busy}, 32'd1);
    idx = 0; ld_cnt = 0; stall_cnt = 0; cyc = 0; got_done = 0;
    prev_en = 1'b0; prev_ld = 1'b0; prev_rsel = 3'd0; stall_addr = 16'd0;
    start = 1'b0;
    while (cyc < 2000) begin
      start = 1'b0; int_stk = 1'b0;
      if (stall_cnt > 0) begin
        check_eq({name, ".stall_en"}, {31'd0, mem_if.psh_en}, 32'd1);
        check_eq({name, ".stall_addr"}, {16'd0, mem_if.psh_addr}, {16'd0, stall_addr});
      end
      if (mem_if.psh_en && (!prev_en || rsel != prev_rsel)) begin
        if (idx < exp_rsel.size()) begin
          check_eq({name, ".rsel"}, {29'd0, rsel}, {29'd0, exp_rsel[idx]});
          check_eq({name, ".addr"}, {16'd0, mem_if.psh_addr}, {16'd0, exp_addr[idx]});
          check_eq({name, ".mem16"}, {31'd0, mem_if.mem16}, {31'd0, exp_m16[idx]});
          check_eq({name, ".wrq"}, {31'd0, mem_if.wrq}, {31'd0, ~epl});
        end
        idx++;
        if (stall && idx == 1) begin
          stall_cnt  = 3;
          stall_addr = mem_if.psh_addr;
        end
        if (idx == 1 && $urandom_range(0, 1) == 1) begin
          start   = 1'b1;
          int_stk = 1'($urandom_range(0, 1));
        end
      end
      if (ld && !prev_ld) ld_cnt++;
      if (done) begin
        got_done = 1;
        break;
      end
      prev_en = mem_if.psh_en; prev_ld = ld; prev_rsel = rsel;
      if (stall_cnt > 0) begin
        cen = 1'b1;
        mem_if.mem_busy = 1'b1;
        stall_cnt--;
      end else begin
        cen = rand_cen ? ($urandom_range(0, 3) != 0) : 1'b1;
        mem_if.mem_busy = 1'($urandom_range(0, 1));
      end
      mem_if.mem_data = 16'($urandom);
      step();
      cyc++;
    end
    start = 1'b0; int_stk = 1'b0;
    check_eq({name, ".done_seen"}, {31'd0, got_done}, 32'd1);
    check_eq({name, ".sp_out"}, {16'd0, sp_out},
             (exp_final < 0) ? {16'd0, exp_sp} : 32'(exp_final));
    check_eq({name, ".sp_we"}, {31'd0, sp_we}, 32'd1);
    check_eq({name, ".busy_dn"}, {31'd0, busy}, 32'd0);
    check_eq({name, ".xfers"}, 32'(idx), 32'(exp_rsel.size()));
    check_eq({name, ".lds"}, 32'(ld_cnt), epl ? 32'(exp_rsel.size()) : 32'd0);
    if (m == 8'd0 && !rand_cen) check_eq({name, ".empty_lat"}, 32'(cyc), 32'd1);
    cen = 1'b1; mem_if.mem_busy = 1'b0;
    step();
    check_eq({name, ".pulse_end"}, {29'd0, done, sp_we, mem_if.psh_en}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; cen = 1'b0; start = 1'b0; pull = 1'b0; use_u = 1'b0; int_stk = 1'b0;
    firq = 1'b0; postbyte = 8'd0; s_in = 16'd0; u_in = 16'd0;
    mem_if.mem_busy = 1'b0; mem_if.mem_data = 16'd0;
    #22;
    check_eq("reset_state", {sp_out, mem_if.psh_addr},  32'd0);
    check_eq("reset_ctl", {22'd0, rsel, ld, sp_we, busy, done, mem_if.psh_en, mem_if.mem16,
                           mem_if.wrq}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    run_seq("push_ab", 16'h1000, 16'h5555, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0FFE);
    run_seq("pull_xpc", 16'h7777, 16'h2000, 8'h90, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 32'h2004);
    run_seq("int_stk", 16'h0005, 16'h1111, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 32'hFFF9);
`ifdef JTKCPU_FIRQ_EN
    run_seq("firq", 16'h3000, 16'h1111, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 32'h2FFD);
`else
    run_seq("firq", 16'h3000, 16'h1111, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 32'h2FF4);
`endif
    run_seq("empty", 16'h1234, 16'h4321, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h1234);
    run_seq("stall", 16'h8000, 16'h0000, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, -1);

    // Abort a 0xFF push while it waits on the memory controller.
    s_in = 16'h4000; postbyte = 8'hFF; pull = 1'b0; use_u = 1'b0; start = 1'b1;
    cen = 1'b1; mem_if.mem_busy = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    check_eq("pre_rst_en", {31'd0, mem_if.psh_en}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid_data", {sp_out, mem_if.psh_addr}, 32'd0);
    check_eq("rst_mid_ctl", {22'd0, rsel, ld, sp_we, busy, done, mem_if.psh_en, mem_if.mem16,
                             mem_if.wrq}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_if.mem_busy = 1'b0;
    step();
    check_eq("post_rst_idle", {30'd0, busy, sp_we}, 32'd0);
    run_seq("after_rst", 16'h0100, 16'h0200, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, -1);

    for (int t = 0; t < 30; t++) begin
      logic ik;
      ik = ($urandom_range(0, 5) == 0);
      run_seq("rand", 16'($urandom), 16'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), ik, 1'($urandom_range(0, 1)), 1, t[0], -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
